rr_index_arbiter: RTL and testbench
===================================

// Module: rr_index_arbiter
// PURPOSE
//   Round-robin arbiter over N request lines; emits the winning requester as a
//   binary index (out_idx) with a valid/ready handshake. Sits directly upstream
//   of the 3-to-8 decoder: out_idx drives decoder.in, decoder.out is the one-hot grant.
//   Fairness: after a grant to i, requester i has lowest priority next round.
// PARAMETERS
//   N      8   number of request lines (power of two, 2..256)
//   IDX_W  3   index width, must equal $clog2(N); 3 matches the decoder input
// PORTS
//   clk        in   1      single clock, all state on posedge
//   reset      in   1      synchronous, active-high
//   req        in   N      request vector, bit i = requester i wants a grant
//   out_valid  out  1      out_idx holds a granted index
//   out_ready  in   1      consumer accepts out_idx this cycle
//   out_idx    out  IDX_W  granted requester index (binary)
//   last_idx   out  IDX_W  index of most recently accepted grant (priority pointer)
// BEHAVIOUR
//   Reset (reset=1 at posedge): out_valid=0, out_idx=0, last_idx=N-1, so first
//     search priority is 0,1,...,N-1. Reset overrides every other event,
//     including a pending unaccepted grant, which is dropped.
//   State: EMPTY (out_valid=0) / HELD (out_valid=1).
//   Search: start = last_idx+1 mod N (wrap N-1 -> 0); winner = first set bit of
//     req scanning start, start+1, ... mod N. Pure combinational over req and last_idx.
//   EMPTY: if |req at posedge -> out_idx<=winner, out_valid<=1 (HELD); latency 1 clk
//     from req sampled to out_valid. If req==0 stay EMPTY, out_idx unchanged.
//   HELD: out_idx and out_valid stable until handshake (out_valid&&out_ready).
//     Grant is sticky: requester dropping req while HELD does not withdraw it.
//     Changes to req while HELD have no effect on out_idx.
//   Handshake edge: last_idx<=out_idx; the same edge re-searches using the new
//     pointer (start = out_idx+1) and current req: if any req -> out_idx<=winner,
//     stay HELD (back-to-back, one grant per clk at full throughput);
//     else out_valid<=0 (EMPTY).
//   out_ready while EMPTY is ignored; last_idx only changes on handshake or reset.
//   Single requester i continuously asserted: granted every handshake (no bubble).
//   All requesters asserted, out_ready=1: grant order 0,1,...,N-1,0,... strictly.
//   No combinational path from out_ready or req to out_valid/out_idx.
// STRUCTURE
//   Shared package: ARB_N=8, ARB_IDX_W=3 constants, state encoding
//     ST_EMPTY=1'b0 / ST_HELD=1'b1.
//   Sub-module rr_pick (combinational): inputs req[N], start[IDX_W]; outputs
//     any, winner[IDX_W]; implemented as rotate-right by start, priority encode,
//     add start mod N. Top level holds state reg, out_idx, last_idx.
// TESTING
//   Reset then req=8'h00, 5 clks -> out_valid=0, out_idx=0, last_idx=7.
//   req=8'hFF, out_ready=1 held -> out_idx sequence 0,1,2,...,7,0 on consecutive
//     clks, out_valid=1 continuously from 1 clk after req.
//   req=8'h24, out_ready=0 for 4 clks -> out_idx=2 stable; then out_ready=1 one
//     clk -> next out_idx=5, last_idx=2; next handshake -> out_idx=2.
//   Grant to 3 held, req drops to 8'h00 -> out_valid stays 1, out_idx=3; handshake
//     -> out_valid=0, last_idx=3; then req=8'h09 -> out_idx=0 (search from 4 wraps).
//   HELD with out_idx=6, assert reset for 1 clk with out_ready=1 -> out_valid=0,
//     out_idx=0, last_idx=7 (reset wins over handshake).
//   Chain into decoder: req=8'h80 -> decoder.out=8'b1000_0000 when out_valid=1.

Source files
------------

// File: rtl/rr_index_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin index arbiter.
package rr_index_arbiter_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin search: first set request at or after 'start',
// wrapping modulo N, returned as a binary index.
import rr_index_arbiter_pkg::*;

module rr_pick #(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic [2*N-1:0]   w_doubled;
  logic [N-1:0]     w_rotated;
  logic [IDX_W-1:0] w_offset;
  logic             w_found;

  // Concatenating req with itself lets a plain right shift act as a rotate.
  assign w_doubled = {req, req};
  assign w_rotated = N'(w_doubled >> start);

  always_comb begin
    w_offset = '0;
    w_found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rotated[i]) begin
        w_offset = IDX_W'(i);
        w_found  = 1'b1;
      end
    end
  end

  // N is a power of two, so the IDX_W-bit add wraps modulo N by itself.
  assign any    = |req;
  assign winner = start + w_offset;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting the winning requester as a binary index with a
// valid/ready handshake; the priority pointer moves only on an accepted grant.
import rr_index_arbiter_pkg::*;

module rr_index_arbiter #(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] last_idx
);

  arb_state_e       r_state;
  arb_state_e       w_nextState;
  logic [IDX_W-1:0] r_outIdx;
  logic [IDX_W-1:0] r_lastIdx;
  logic [IDX_W-1:0] w_nextOutIdx;
  logic [IDX_W-1:0] w_nextLastIdx;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_start;
  logic             w_any;
  logic [IDX_W-1:0] w_winner;

  // On a handshake the just-accepted index becomes the new pointer, so the
  // same-edge re-search starts after out_idx rather than after last_idx.
  assign w_base  = (r_state == ST_HELD) ? r_outIdx : r_lastIdx;
  assign w_start = w_base + IDX_W'(1);

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .start  (w_start),
    .any    (w_any),
    .winner (w_winner)
  );

  always_comb begin
    w_nextState   = r_state;
    w_nextOutIdx  = r_outIdx;
    w_nextLastIdx = r_lastIdx;
    if (r_state == ST_EMPTY) begin
      if (w_any) begin
        w_nextState  = ST_HELD;
        w_nextOutIdx = w_winner;
      end
    end else if (out_ready) begin
      w_nextLastIdx = r_outIdx;
      if (w_any) begin
        w_nextOutIdx = w_winner;
      end else begin
        w_nextState = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_outIdx  <= '0;
      r_lastIdx <= IDX_W'(N - 1);
    end else begin
      r_state   <= w_nextState;
      r_outIdx  <= w_nextOutIdx;
      r_lastIdx <= w_nextLastIdx;
    end
  end

  assign out_valid = (r_state == ST_HELD);
  assign out_idx   = r_outIdx;
  assign last_idx  = r_lastIdx;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench: directed vector table, a decoder chain check, and a
// randomized run against a round-robin reference model.
module tb_rr_index_arbiter;

  localparam int N = 8;

  typedef struct {
    bit       rst;
    bit [7:0] req;
    bit       rdy;
    bit       expValid;
    int       expIdx;
    int       expLast;
    string    name;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       outReady;
  logic       outValid;
  logic [2:0] outIdx;
  logic [2:0] lastIdx;

  int checkCount;
  int errorCount;

  bit modelValid;
  int modelIdx;
  int modelLast;

  vec_t vecs[$];

  rr_index_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_idx   (outIdx),
    .last_idx  (lastIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference search: walk the ring starting just after the pointer.
  function automatic int searchFrom(input bit [7:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic modelStep(input bit rst, input bit [7:0] r, input bit rdy);
    if (rst) begin
      modelValid = 1'b0;
      modelIdx   = 0;
      modelLast  = N - 1;
    end else if (!modelValid) begin
      if (r != 8'h00) begin
        modelIdx   = searchFrom(r, modelLast);
        modelValid = 1'b1;
      end
    end else if (rdy) begin
      modelLast = modelIdx;
      if (r != 8'h00) modelIdx = searchFrom(r, modelLast);
      else modelValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit [7:0] r, input bit rdy);
    @(negedge clk);
    reset    = rst;
    req      = r;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit expValid,
                             input int expIdx, input int expLast);
    checkCount++;
    if (outValid !== expValid || int'(outIdx) != expIdx || int'(lastIdx) != expLast) begin
      errorCount++;
      $display("[TB] FAIL %s: got valid=%0b idx=%0d last=%0d, want valid=%0b idx=%0d last=%0d",
               name, outValid, outIdx, lastIdx, expValid, expIdx, expLast);
    end
  endtask

  task automatic addVec(input bit rst, input bit [7:0] r, input bit rdy,
                        input bit v, input int idx, input int last, input string name);
    vec_t e;
    e.rst = rst; e.req = r; e.rdy = rdy;
    e.expValid = v; e.expIdx = idx; e.expLast = last; e.name = name;
    vecs.push_back(e);
  endtask

  initial begin
    bit [7:0] rr;
    bit       rs;
    bit       rd;
    bit [7:0] oneHot;

    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    req        = 8'h00;
    outReady   = 1'b0;

    addVec(1, 8'h00, 0, 0, 0, 7, "reset");
    for (int i = 0; i < 5; i++) addVec(0, 8'h00, 0, 0, 0, 7, "idle");
    addVec(0, 8'h00, 1, 0, 0, 7, "ready_while_empty");
    for (int i = 0; i < 8; i++) addVec(0, 8'hFF, 1, 1, i, (i + 7) % 8, "all_req_seq");
    addVec(0, 8'hFF, 1, 1, 0, 7, "all_req_wrap");
    addVec(1, 8'h00, 0, 0, 0, 7, "reset2");
    for (int i = 0; i < 4; i++) addVec(0, 8'h24, 0, 1, 2, 7, "hold_stable");
    addVec(0, 8'h24, 1, 1, 5, 2, "handshake_to5");
    addVec(0, 8'h24, 1, 1, 2, 5, "handshake_to2");
    addVec(1, 8'h00, 0, 0, 0, 7, "reset3");
    addVec(0, 8'h08, 0, 1, 3, 7, "grant3");
    addVec(0, 8'h00, 0, 1, 3, 7, "sticky_grant");
    addVec(0, 8'h00, 1, 0, 3, 3, "drain_empty");
    addVec(0, 8'h09, 0, 1, 0, 3, "wrap_search");
    addVec(1, 8'h00, 0, 0, 0, 7, "reset4");
    addVec(0, 8'h40, 0, 1, 6, 7, "grant6");
    addVec(1, 8'h40, 1, 0, 0, 7, "reset_beats_hs");
    addVec(0, 8'h10, 1, 1, 4, 7, "single_req");
    addVec(0, 8'h10, 1, 1, 4, 4, "single_no_bubble");
    addVec(0, 8'h10, 1, 1, 4, 4, "single_no_bubble2");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rdy);
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expIdx, vecs[i].expLast);
    end

    // Decoder chain: one-hot grant derived from out_idx for a lone top requester.
    applyStimulus(1, 8'h00, 0);
    applyStimulus(0, 8'h80, 0);
    checkOutput("dec_grant7", 1, 7, 7);
    oneHot = 8'h01 << outIdx;
    checkCount++;
    if (!outValid || oneHot !== 8'b1000_0000) begin
      errorCount++;
      $display("[TB] FAIL decoder_onehot: got %b, want 10000000", oneHot);
    end

    // Randomized run against the reference model.
    applyStimulus(1, 8'h00, 0);
    modelStep(1, 8'h00, 0);
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       rr = 8'h00;
        1:       rr = 8'h01 << $urandom_range(0, 7);
        default: rr = 8'($urandom);
      endcase
      rs = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 2) != 0);
      applyStimulus(rs, rr, rd);
      modelStep(rs, rr, rd);
      checkOutput("random", modelValid, modelIdx, modelLast);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
